// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control FSM: IF/ID/EXEC/MEM/WB/TRAP sequencing with Moore decode.
// Optional performance counters are built only when MC_CTRL_PERF_EN is defined.
module mc_control_fsm #(
    parameter int unsigned CNT_W           = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic [2:0]       state,
    output logic             pc_we,
    output logic             ir_we,
    output logic             mem_we,
    output logic             reg_we,
    output logic             a_we,
    output logic             b_we,
    output logic             mem_in,
    output logic [1:0]       reg_dst,
    output logic [1:0]       reg_in,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             imm_zext,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB  = 6'h22, FN_SLT  = 6'h2A, FN_JR = 6'h08;

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic [5:0] funct_q, funct_d;

    logic unused_instr;
    assign unused_instr = ^instr[25:6];

    logic is_r_alu, is_jr, is_j, is_jal, is_br, is_imm, is_lw, is_sw, is_legal;
    always_comb begin
        is_r_alu = (opcode_q == OP_RTYPE) &&
                   (funct_q == FN_ADD || funct_q == FN_SUB || funct_q == FN_SLT);
        is_jr    = (opcode_q == OP_RTYPE) && (funct_q == FN_JR);
        is_j     = (opcode_q == OP_J);
        is_jal   = (opcode_q == OP_JAL);
        is_br    = (opcode_q == OP_BEQ) || (opcode_q == OP_BNE);
        is_imm   = (opcode_q == OP_ADDI) || (opcode_q == OP_XORI);
        is_lw    = (opcode_q == OP_LW);
        is_sw    = (opcode_q == OP_SW);
        is_legal = is_r_alu || is_jr || is_j || is_jal || is_br || is_imm || is_lw || is_sw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IF;
            opcode_q <= 6'h00;
            funct_q  <= 6'h00;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        funct_d  = funct_q;
        case (state_q)
            S_IF: if (mem_ready) begin
                opcode_d = instr[31:26];
                funct_d  = instr[5:0];
                state_d  = S_ID;
            end
            S_ID: begin
                if (is_j || is_jal)  state_d = S_IF;
                else if (!is_legal)  state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_IF;
                else                 state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_r_alu || is_imm)  state_d = S_WB;
                else if (is_lw || is_sw) state_d = S_MEM;
                else                     state_d = S_IF;
            end
            S_MEM: if (mem_ready) state_d = is_lw ? S_WB : S_IF;
            S_WB:   state_d = S_IF;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        a_we      = 1'b0;
        b_we      = 1'b0;
        mem_in    = 1'b0;
        reg_dst   = 2'd0;
        reg_in    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        imm_zext  = 1'b0;
        alu_op    = 3'd0;
        pc_src    = 2'd0;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_IF: begin
                // State resets to IF, so gating with rst_n keeps enables low during reset.
                alu_src_b = 2'd1;
                pc_we     = mem_ready & rst_n;
                ir_we     = mem_ready & rst_n;
            end
            S_ID: begin
                a_we      = 1'b1;
                b_we      = 1'b1;
                alu_src_b = 2'd3;
                if (is_j || is_jal) begin
                    pc_we  = 1'b1;
                    pc_src = 2'd2;
                    retire = 1'b1;
                end
                if (is_jal) begin
                    reg_we  = 1'b1;
                    reg_dst = 2'd2;
                    reg_in  = 2'd2;
                end
                if (!is_legal && !TRAP_ON_ILLEGAL) retire = 1'b1;
            end
            S_EXEC: begin
                if (is_r_alu) begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd0;
                    alu_op    = (funct_q == FN_SUB) ? 3'd1 :
                                (funct_q == FN_SLT) ? 3'd3 : 3'd0;
                end else if (is_jr) begin
                    pc_we  = 1'b1;
                    pc_src = 2'd3;
                    retire = 1'b1;
                end else if (is_imm || is_lw || is_sw) begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    if (opcode_q == OP_XORI) begin
                        alu_op   = 3'd2;
                        imm_zext = 1'b1;
                    end
                end else if (is_br) begin
                    alu_src_a = 2'd1;
                    alu_op    = 3'd1;
                    pc_src    = 2'd1;
                    pc_we     = (opcode_q == OP_BEQ) ? alu_zero : ~alu_zero;
                    retire    = 1'b1;
                end
            end
            S_MEM: begin
                mem_in = 1'b1;
                if (is_sw) begin
                    mem_we = 1'b1;
                    retire = mem_ready;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                retire = 1'b1;
                if (is_r_alu)   reg_dst = 2'd1;
                else if (is_lw) reg_in  = 2'd1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

`ifdef MC_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else if (state_q != S_TRAP) begin
            cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
            if (retire) instr_cnt_q <= instr_cnt_q + CNT_ONE;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench: each issued instruction pushes its expected retire record; a monitor
// pops and compares on every retire pulse. Directed checks cover reset, trap and counters.
module tb_mc_control_fsm;
`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic mem_ready = 1'b1, alu_zero = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] state, alu_op;
    logic pc_we, ir_we, mem_we, reg_we, a_we, b_we, mem_in, imm_zext, retire, illegal;
    logic [1:0] reg_dst, reg_in, alu_src_a, alu_src_b, pc_src;
    logic [3:0] cycle_cnt, instr_cnt;

    logic [2:0] n_state, n_alu_op;
    logic n_pc_we, n_ir_we, n_mem_we, n_reg_we, n_a_we, n_b_we, n_mem_in, n_imm_zext, n_retire, n_illegal;
    logic [1:0] n_reg_dst, n_reg_in, n_alu_src_a, n_alu_src_b, n_pc_src;
    logic [3:0] n_cycle_cnt, n_instr_cnt;

    mc_control_fsm #(.CNT_W(4), .TRAP_ON_ILLEGAL(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .state(state), .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we), .reg_we(reg_we),
        .a_we(a_we), .b_we(b_we), .mem_in(mem_in), .reg_dst(reg_dst), .reg_in(reg_in),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op),
        .pc_src(pc_src), .retire(retire), .illegal(illegal),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));

    mc_control_fsm #(.CNT_W(4), .TRAP_ON_ILLEGAL(1'b0)) u_nop (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .state(n_state), .pc_we(n_pc_we), .ir_we(n_ir_we), .mem_we(n_mem_we), .reg_we(n_reg_we),
        .a_we(n_a_we), .b_we(n_b_we), .mem_in(n_mem_in), .reg_dst(n_reg_dst), .reg_in(n_reg_in),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .imm_zext(n_imm_zext), .alu_op(n_alu_op),
        .pc_src(n_pc_src), .retire(n_retire), .illegal(n_illegal),
        .cycle_cnt(n_cycle_cnt), .instr_cnt(n_instr_cnt));

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] reg_in;
        logic [2:0] eop;   // alu_op seen in EXEC
        logic       zx;    // imm_zext seen at any point
        logic [3:0] mwe;   // cycles with mem_we
        logic [3:0] irw;   // cycles with ir_we
        logic [7:0] cyc;   // cycles from fetch start to retire, inclusive
    } rec_t;

    rec_t q[$];
    int checks = 0, errors = 0;
    int ecyc = 0, einst = 0;

    logic [7:0] a_cyc;
    logic [3:0] a_mwe, a_irw;
    logic [2:0] a_eop;
    logic       a_zx;
    rec_t got, exp_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_cyc = 0; a_mwe = 0; a_irw = 0; a_eop = 0; a_zx = 0;
        end else begin
            a_cyc++;
            if (mem_we) a_mwe++;
            if (ir_we) a_irw++;
            if (imm_zext) a_zx = 1'b1;
            if (state == 3'd2) a_eop = alu_op;
            if (retire) begin
                got = '{state, pc_we, pc_src, reg_we, reg_dst, reg_in, a_eop, a_zx, a_mwe, a_irw, a_cyc};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL retire_unexpected got=%h expected no retire", got);
                end else begin
                    exp_r = q.pop_front();
                    if (got !== exp_r) begin
                        errors++;
                        $display("FAIL retire_record got=%h expected=%h", got, exp_r);
                    end
                end
                a_cyc = 0; a_mwe = 0; a_irw = 0; a_eop = 0; a_zx = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] cexp(input int v);
        cexp = PERF ? 32'(v % 16) : 32'd0;
    endfunction

    // Called at posedge+1 with the DUT in IF; returns at posedge+1 once it is back in IF.
    task automatic run(input logic [31:0] iw, input logic az, input int ifs, input int mems,
                       input rec_t e);
        int n, g;
        q.push_back(e);
        ecyc += int'(e.cyc);
        einst++;
        instr = iw; alu_zero = az; mem_ready = 1'b0;
        for (int i = 0; i < ifs; i++) begin @(posedge clk); #1; end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        n = 0; g = 0;
        mem_ready = (mems == 0);
        while (state != 3'd0 && g < 40) begin
            if (state == 3'd3) begin
                if (n >= mems) mem_ready = 1'b1;
                else begin mem_ready = 1'b0; n++; end
            end
            @(posedge clk); #1; g++;
        end
        if (g >= 40) begin
            checks++; errors++;
            $display("FAIL timeout_return_to_if instr=%h state=%0d required=0", iw, state);
        end
        chk("cycle_cnt", 32'(cycle_cnt), cexp(ecyc));
        chk("instr_cnt", 32'(instr_cnt), cexp(einst));
    endtask

    //                     st pcw pcs rw rd ri eop zx mwe irw cyc
    localparam rec_t R_J    = '{3'd1, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 4'd0, 4'd1, 8'd2};
    localparam rec_t R_JAL  = '{3'd1, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 3'd0, 1'b0, 4'd0, 4'd1, 8'd2};
    localparam rec_t R_ADD  = '{3'd4, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 3'd0, 1'b0, 4'd0, 4'd1, 8'd4};
    localparam rec_t R_SUB  = '{3'd4, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 3'd1, 1'b0, 4'd0, 4'd1, 8'd4};
    localparam rec_t R_SLT  = '{3'd4, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 3'd3, 1'b0, 4'd0, 4'd1, 8'd4};
    localparam rec_t R_LW   = '{3'd4, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 3'd0, 1'b0, 4'd0, 4'd1, 8'd5};
    localparam rec_t R_LWS  = '{3'd4, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 3'd0, 1'b0, 4'd0, 4'd1, 8'd7};
    localparam rec_t R_BT   = '{3'd2, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 3'd1, 1'b0, 4'd0, 4'd1, 8'd3};
    localparam rec_t R_BN   = '{3'd2, 1'b0, 2'd1, 1'b0, 2'd0, 2'd0, 3'd1, 1'b0, 4'd0, 4'd1, 8'd3};
    localparam rec_t R_SWS  = '{3'd3, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 4'd4, 4'd1, 8'd7};
    localparam rec_t R_ADDI = '{3'd4, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 3'd0, 1'b0, 4'd0, 4'd1, 8'd6};
    localparam rec_t R_XORI = '{3'd4, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 3'd2, 1'b1, 4'd0, 4'd1, 8'd4};
    localparam rec_t R_JR   = '{3'd2, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 4'd0, 4'd1, 8'd3};

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] en;
        rst_n = 1'b0; mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_state", 32'(state), 32'd0);
            chk("rst_enables", 32'({pc_we, ir_we, mem_we, reg_we, a_we, b_we, retire, illegal}), 32'd0);
            chk("rst_selects", 32'({mem_in, alu_src_a, alu_src_b, alu_op, pc_src}), 32'({1'b0, 2'd0, 2'd1, 3'd0, 2'd0}));
        end
        chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("release_pc_ir_we", 32'({pc_we, ir_we}), 32'b11);

        repeat (6) run(32'h0800_0000, 1'b0, 0, 0, R_J);
        run(32'h012A_4020, 1'b0, 0, 0, R_ADD);   // cycle_cnt wraps 15->0 here
        run(32'h8D09_0004, 1'b0, 0, 0, R_LW);
        run(32'h1109_0003, 1'b1, 0, 0, R_BT);    // BEQ taken
        run(32'h1509_0003, 1'b1, 0, 0, R_BN);    // BNE not taken
        run(32'h1109_0003, 1'b0, 0, 0, R_BN);    // BEQ not taken
        run(32'h1509_0003, 1'b0, 0, 0, R_BT);    // BNE taken
        run(32'hAD09_0004, 1'b0, 0, 3, R_SWS);
        run(32'h8D09_0004, 1'b0, 0, 2, R_LWS);
        run(32'h2109_0005, 1'b0, 2, 0, R_ADDI);
        run(32'h3909_FFFF, 1'b0, 0, 0, R_XORI);
        run(32'h0120_0008, 1'b0, 0, 0, R_JR);
        run(32'h0C00_0010, 1'b0, 0, 0, R_JAL);
        run(32'h012A_4022, 1'b0, 0, 0, R_SUB);
        run(32'h012A_402A, 1'b0, 0, 0, R_SLT);

        instr = 32'hFC00_0000; mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("ill_id_state", 32'(state), 32'd1);
        chk("ill_id_no_retire", 32'(retire), 32'd0);
        chk("nop_id_retire", 32'(n_retire), 32'd1);
        @(posedge clk); #1;
        ecyc += 2;
        chk("nop_back_to_if", 32'({n_state, n_illegal}), 32'd0);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            en = {pc_we, ir_we, mem_we, reg_we, a_we, b_we, retire};
            chk("trap_hold", 32'({state, illegal, en}), 32'({3'd5, 1'b1, 7'd0}));
            @(posedge clk); #1;
        end
        chk("trap_cycle_frozen", 32'(cycle_cnt), cexp(ecyc));
        chk("trap_instr_frozen", 32'(instr_cnt), cexp(einst));

        rst_n = 1'b0;
        #1;
        chk("trap_reset", 32'({state, illegal, cycle_cnt, instr_cnt}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ecyc = 0; einst = 0;
        run(32'h0800_0000, 1'b0, 0, 0, R_J);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
